regfile_mp: RTL

//   Parametrised multi-port register file for the MIPS datapath; next generation of
//   the 2R/1W regfile. It has a configurable number of read and write ports, an

---
 rtl/regfile_mp.sv | 97 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file for the MIPS datapath.
// It has NREAD read ports and NWRITE write ports. Register 0 can be hardwired to zero.
// A write can be forwarded to a read in the same cycle, and the read data can be
// registered so that decode can be pipelined.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int R0_ZERO  = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREAD*ADDR_W-1:0]  raddr,
    output logic [NREAD*DATA_W-1:0]  rdata,
    input  logic [NWRITE-1:0]        we,
    input  logic [NWRITE*ADDR_W-1:0] waddr,
    input  logic [NWRITE*DATA_W-1:0] wdata
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Storage array and unpacked views of the flat port buses
    logic [DATA_W-1:0]       mem     [DEPTH];
    logic [ADDR_W-1:0]       ra      [NREAD];
    logic [ADDR_W-1:0]       wa      [NWRITE];
    logic [DATA_W-1:0]       wd      [NWRITE];
    logic [DATA_W-1:0]       rd_comb [NREAD];
    logic [NWRITE-1:0]       wkeep;    // write enable after writes to a hardwired r0 are dropped
    logic [NREAD*DATA_W-1:0] rd_flat;  // same-cycle read value, packed like rdata

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rport
            assign ra[gi] = raddr[gi*ADDR_W +: ADDR_W];
            assign rd_flat[gi*DATA_W +: DATA_W] = rd_comb[gi];
        end
        for (gi = 0; gi < NWRITE; gi++) begin : g_wport
            assign wa[gi]    = waddr[gi*ADDR_W +: ADDR_W];
            assign wd[gi]    = wdata[gi*DATA_W +: DATA_W];
            assign wkeep[gi] = we[gi] && !((R0_ZERO != 0) && (wa[gi] == '0));
        end
    endgenerate

    // Reset clears every entry. Otherwise ports commit in ascending order, so the highest index wins a conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (wkeep[j]) begin
                    mem[wa[j]] <= wd[j];
                end
            end
        end
    end

    // Same-cycle read value: array value, overridden by the highest-index hitting write, then r0 forced to zero
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_comb[i] = mem[ra[i]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (we[j] && (wa[j] == ra[i])) begin
                        rd_comb[i] = wd[j];
                    end
                end
            end
            if ((R0_ZERO != 0) && (ra[i] == '0)) begin
                rd_comb[i] = '0;
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_rreg
            logic [NREAD*DATA_W-1:0] rq;

            // Register the same-cycle read value. This gives one cycle of latency and keeps the bypass effect.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rq <= '0;
                end else begin
                    rq <= rd_flat;
                end
            end

            assign rdata = rq;
        end else begin : g_rcomb
            assign rdata = rd_flat;
        end
    endgenerate

endmodule
